// File: rtl/mult_pkg.sv
// Shared definitions for the sliced sequential multiplier: state encodings,
// the state typedef and the counter-width helper.
package mult_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'b000,
    ST_CALC = 3'b001,
    ST_DONE = 3'b010,
    ST_ERR  = 3'b011
  } state_t;

  // Width of the partial-product counter: max(1, clog2(np)).
  function automatic int cnt_width(input int np);
    return (np <= 2) ? 1 : $clog2(np);
  endfunction

endpackage

// File: rtl/mult_slice.sv
// Combinational unsigned W x W multiplier producing the full 2W-bit product.
module mult_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  // Operands are zero-extended to the result width so no high bits are lost.
  always_comb begin
    o_p = (2*W)'(i_a) * (2*W)'(i_b);
  end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential unsigned multiplier: one SLICE_W x SLICE_W partial product per
// cycle, shifted into place and summed into a full-width accumulator.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands latched when start is accepted
// CALC  | one partial product per cycle; start here aborts to ERR
// DONE  | one-cycle done pulse, start ignored, returns to IDLE
// ERR   | aborted; holds until a new start (treated as from IDLE)
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int A_W     = 8,
  parameter int B_W     = 8,
  parameter int SLICE_W = 4
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               start,
  input  logic [A_W-1:0]     dataa,
  input  logic [B_W-1:0]     datab,
  output logic [A_W+B_W-1:0] product,
  output logic               done,
  output logic               busy,
  output logic               error,
  output logic [2:0]         state_out
);

  localparam int NA    = A_W / SLICE_W;
  localparam int NB    = B_W / SLICE_W;
  localparam int NP    = NA * NB;
  localparam int CNT_W = cnt_width(NP);
  localparam int P_W   = A_W + B_W;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NP - 1);

  // Operand widths that do not split evenly into slices are rejected outright.
  if (SLICE_W < 1 || (A_W % SLICE_W) != 0 || (B_W % SLICE_W) != 0) begin : g_bad_width
    $error("seq_mult_param: A_W and B_W must be multiples of SLICE_W");
  end

  state_t             r_state;
  state_t             w_next;
  logic [A_W-1:0]     r_a;
  logic [B_W-1:0]     r_b;
  logic [P_W-1:0]     r_acc;
  logic [P_W-1:0]     r_product;
  logic [CNT_W-1:0]   r_cnt;

  logic [31:0]        w_k;
  logic [31:0]        w_i;
  logic [31:0]        w_j;
  logic [31:0]        w_shift;
  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [2*SLICE_W-1:0] w_pp;
  logic [P_W-1:0]     w_pp_aligned;
  logic [P_W-1:0]     w_acc_sum;
  logic               w_last;
  logic               w_accept;

  // Slice selection: count k walks the A slices fastest, then steps B.
  always_comb begin
    w_k       = 32'(r_cnt);
    w_i       = w_k % NA;
    w_j       = w_k / NA;
    w_shift   = (w_i + w_j) * SLICE_W;
    w_a_slice = SLICE_W'(r_a >> (w_i * SLICE_W));
    w_b_slice = SLICE_W'(r_b >> (w_j * SLICE_W));
  end

  mult_slice #(
    .W (SLICE_W)
  ) u_slice (
    .i_a (w_a_slice),
    .i_b (w_b_slice),
    .o_p (w_pp)
  );

  // Align the partial product and form the running sum; the accumulator is
  // as wide as the full product, so the exact result always fits.
  always_comb begin
    w_pp_aligned = P_W'(w_pp) << w_shift;
    w_acc_sum    = r_acc + w_pp_aligned;
    w_last       = (r_cnt == LAST_CNT);
    w_accept     = start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_a) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; unused encodings recover to IDLE.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next = start ? ST_CALC : ST_IDLE;
      ST_CALC: begin
        if (start) begin
          w_next = ST_ERR;
        end else if (w_last) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_CALC;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = start ? ST_CALC : ST_ERR;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture and accumulation; operands are frozen for the whole CALC.
  always_ff @(posedge clk) begin
    if (!reset_a) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= dataa;
      r_b   <= datab;
      r_acc <= '0;
      r_cnt <= '0;
    end else if ((r_state == ST_CALC) && !start) begin
      r_acc <= w_acc_sum;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result register: loads on the edge into DONE, clears on abort or reset.
  always_ff @(posedge clk) begin
    if (!reset_a) begin
      r_product <= '0;
    end else if (r_state == ST_CALC) begin
      if (start) begin
        r_product <= '0;
      end else if (w_last) begin
        r_product <= w_acc_sum;
      end
    end
  end

  // Status outputs are plain decodes of the state register.
  always_comb begin
    done      = (r_state == ST_DONE);
    busy      = (r_state == ST_CALC);
    error     = (r_state == ST_ERR);
    state_out = r_state;
    product   = r_product;
  end

endmodule

// File: tb/tb_seq_mult_param.sv
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        s0, s1;
  logic [7:0]  a0, b0;
  logic [15:0] a1;
  logic [7:0]  b1;
  logic [15:0] p0;
  logic [23:0] p1;
  logic        dn0, bs0, er0, dn1, bs1, er1;
  logic [2:0]  so0, so1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_mult_param u_dut0 (
    .clk       (clk),
    .reset_a   (rst_b),
    .start     (s0),
    .dataa     (a0),
    .datab     (b0),
    .product   (p0),
    .done      (dn0),
    .busy      (bs0),
    .error     (er0),
    .state_out (so0)
  );

  seq_mult_param #(
    .A_W     (16),
    .B_W     (8),
    .SLICE_W (4)
  ) u_dut1 (
    .clk       (clk),
    .reset_a   (rst_b),
    .start     (s1),
    .dataa     (a1),
    .datab     (b1),
    .product   (p1),
    .done      (dn1),
    .busy      (bs1),
    .error     (er1),
    .state_out (so1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: exact product computed at acceptance, released after
  // NP busy cycles; phase codes 0 idle, 1 calc, 2 done, 3 err.
  logic [2:0]  m_st   [2];
  int          m_left [2];
  logic [23:0] m_res  [2];
  logic [23:0] m_prod [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        st;
      logic [23:0] exact;
      int          np;
      st    = (d == 0) ? s0 : s1;
      exact = (d == 0) ? 24'(a0) * 24'(b0) : 24'(a1) * 24'(b1);
      np    = (d == 0) ? 4 : 8;
      if (!rst_b) begin
        m_st[d]   = 3'd0;
        m_left[d] = 0;
        m_prod[d] = 24'd0;
      end else begin
        case (m_st[d])
          3'd0, 3'd3: begin
            if (st) begin
              m_st[d]   = 3'd1;
              m_left[d] = np;
              m_res[d]  = exact;
            end
          end
          3'd1: begin
            if (st) begin
              m_st[d]   = 3'd3;
              m_prod[d] = 24'd0;
            end else begin
              m_left[d] = m_left[d] - 1;
              if (m_left[d] == 0) begin
                m_st[d]   = 3'd2;
                m_prod[d] = m_res[d];
              end
            end
          end
          default: m_st[d] = 3'd0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m0_state", 32'(so0), 32'(m_st[0]));
      chk("m0_done",  32'(dn0), 32'(m_st[0] == 3'd2));
      chk("m0_busy",  32'(bs0), 32'(m_st[0] == 3'd1));
      chk("m0_error", 32'(er0), 32'(m_st[0] == 3'd3));
      chk("m0_prod",  32'(p0),  32'(m_prod[0][15:0]));
      chk("m1_state", 32'(so1), 32'(m_st[1]));
      chk("m1_done",  32'(dn1), 32'(m_st[1] == 3'd2));
      chk("m1_busy",  32'(bs1), 32'(m_st[1] == 3'd1));
      chk("m1_error", 32'(er1), 32'(m_st[1] == 3'd3));
      chk("m1_prod",  32'(p1),  32'(m_prod[1]));
    end
  end

  // Called at the negedge just after the accepting edge (cycle 1 of CALC).
  task automatic wait_done(input int d, input int exp_n, input logic [23:0] exp_p,
                           input string nm, input bit scr);
    int n  = 1;
    int nb = 0;
    while (!((d == 0) ? dn0 : dn1) && n < 30) begin
      if ((d == 0) ? bs0 : bs1) nb++;
      if (scr) begin
        a0 = 8'($urandom);
        b0 = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_n));
    chk({nm, "_busycyc"}, 32'(nb), 32'(exp_n - 1));
    chk({nm, "_product"}, (d == 0) ? 32'(p0) : 32'(p1), 32'(exp_p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;
    s0 = 1'b0; s1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_state", 32'(so0), 32'd0);
    chk("rst_prod",  32'(p0),  32'd0);
    chk("rst_flags", {29'd0, dn0, bs0, er0}, 32'd0);
    chk("rst_prod1", 32'(p1),  32'd0);

    // 0xFF * 0xFF, start accepted on the very first edge out of reset
    rst_b = 1'b1;
    a0 = 8'hFF; b0 = 8'hFF; s0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    wait_done(0, 5, 24'h00FE01, "ff_ff", 1'b0);

    // abort in the second CALC cycle
    @(negedge clk);
    a0 = 8'h12; b0 = 8'h34; s0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    @(negedge clk); s0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    chk("abort_error", 32'(er0), 32'd1);
    chk("abort_prod",  32'(p0),  32'd0);
    chk("abort_state", 32'(so0), 32'd3);
    repeat (2) @(negedge clk);
    chk("err_hold", 32'(so0), 32'd3);
    a0 = 8'h03; b0 = 8'h05; s0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    wait_done(0, 5, 24'h00000F, "after_err", 1'b0);
    chk("after_err_error", 32'(er0), 32'd0);

    // wide configuration: 16x8 with 4-bit slices
    @(negedge clk);
    a1 = 16'h1234; b1 = 8'h56; s1 = 1'b1;
    @(negedge clk); s1 = 1'b0;
    wait_done(1, 9, 24'h061D78, "wide", 1'b0);

    // zero multiplicand, operands scrambled during CALC
    @(negedge clk);
    a0 = 8'h00; b0 = 8'hA5; s0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    wait_done(0, 5, 24'h000000, "zero", 1'b1);

    // start held high across DONE: ignored there, accepted in following IDLE
    @(negedge clk);
    a0 = 8'h02; b0 = 8'h03; s0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    wait_done(0, 5, 24'h000006, "b2b_first", 1'b0);
    a0 = 8'h04; b0 = 8'h06; s0 = 1'b1;
    @(negedge clk);
    chk("b2b_ignored", 32'(so0), 32'd0);
    @(negedge clk);
    chk("b2b_accepted", 32'(so0), 32'd1);
    s0 = 1'b0;
    wait_done(0, 5, 24'h000018, "b2b_second", 1'b0);

    // reset in the third CALC cycle
    @(negedge clk);
    a0 = 8'h77; b0 = 8'h99; s0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(so0), 32'd0);
    chk("midrst_prod",  32'(p0),  32'd0);
    chk("midrst_flags", {29'd0, dn0, bs0, er0}, 32'd0);
    rst_b = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midrst_nodone", 32'(dn0), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
